// File: rtl/serial_shifter.sv
// Multi-cycle shift unit (SLL/SRL/SRA/ROR). Each SHIFT cycle moves the working register one bit position.
// With SERIAL_SHIFTER_NIBBLE_EN defined, a SHIFT cycle moves four positions while at least four remain.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_IDLE  | waiting for a request
// ST_SHIFT | shift in progress, busy=1
// ST_DONE  | completion cycle, done=1, result valid
module serial_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [WIDTH-1:0]   shift1;
   logic [WIDTH-1:0]   shift4;

   always_comb begin
      shift1 = work_q;
      case (op_q)
         OP_SLL:  shift1 = {work_q[WIDTH-2:0], 1'b0};
         OP_SRL:  shift1 = {1'b0, work_q[WIDTH-1:1]};
         OP_SRA:  shift1 = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         OP_ROR:  shift1 = {work_q[0], work_q[WIDTH-1:1]};
         default: shift1 = work_q;
      endcase
   end

   always_comb begin
      shift4 = work_q;
      case (op_q)
         OP_SLL:  shift4 = {work_q[WIDTH-5:0], 4'b0000};
         OP_SRL:  shift4 = {4'b0000, work_q[WIDTH-1:4]};
         OP_SRA:  shift4 = {{4{work_q[WIDTH-1]}}, work_q[WIDTH-1:4]};
         OP_ROR:  shift4 = {work_q[3:0], work_q[WIDTH-1:4]};
         default: shift4 = work_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      count_d  = count_q;
      op_d     = op_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               work_d  = data_in;
               count_d = shamt;
               op_d    = op;
               if (shamt == '0) begin
                  state_d  = ST_DONE;
                  result_d = data_in;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end

         ST_SHIFT: begin
`ifdef SERIAL_SHIFTER_NIBBLE_EN
            if (count_q >= SHAMT_W'(4)) begin
               work_d  = shift4;
               count_d = count_q - SHAMT_W'(4);
            end else begin
               work_d  = shift1;
               count_d = count_q - SHAMT_W'(1);
            end
`else
            work_d  = shift1;
            count_d = count_q - SHAMT_W'(1);
`endif
            // result only moves on entry to DONE; it holds the previous value while shifting
            if (count_d == '0) begin
               state_d  = ST_DONE;
               result_d = work_d;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

`ifndef SERIAL_SHIFTER_NIBBLE_EN
   logic unused_shift4;
   assign unused_shift4 = ^shift4;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         count_q  <= '0;
         op_q     <= OP_SLL;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         count_q  <= count_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == ST_SHIFT);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Bench for serial_shifter: directed and random operations against an arithmetic shift model.
module tb_serial_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_result;

   serial_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .data_in (data_in),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
      logic [31:0] r;
      case (o)
         2'd0: r = d << s;
         2'd1: r = d >> s;
         2'd2: r = 32'($signed(d) >>> s);
         default: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input int s);
`ifdef SERIAL_SHIFTER_NIBBLE_EN
      return (s / 4) + (s % 4) + 1;
`else
      return s + 1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
      start   = 1'b1;
      op      = o;
      data_in = d;
      shamt   = s;
   endtask

   // Waits for done after an issue; while busy the inputs are scrambled to show they are ignored.
   task automatic finish_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                            input logic [4:0] s, input bit keep);
      int cyc = 0;
      bit seen = 0;
      logic [31:0] exp = model(o, d, int'(s));
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen = 1;
         end else begin
            chk({tag, "/busy"}, 32'(busy), 32'd1);
            chk({tag, "/hold"}, result, last_result);
            start   = 1'($urandom);
            op      = 2'($urandom);
            data_in = $urandom;
            shamt   = 5'($urandom);
         end
      end
      chk({tag, "/timeout"}, 32'(seen), 32'd1);
      chk({tag, "/latency"}, 32'(cyc), 32'(exp_lat(int'(s))));
      chk({tag, "/result"}, result, exp);
      chk({tag, "/busy_done"}, 32'(busy), 32'd0);
      last_result = exp;
      if (!keep) begin
         start = 1'b0;
         @(negedge clk);
         chk({tag, "/pulse"}, {30'd0, busy, done}, 32'd0);
         chk({tag, "/stable"}, result, last_result);
      end
   endtask

   initial begin
      bit   any_done;
      logic [1:0]  ro;
      logic [31:0] rd;
      logic [4:0]  rs;
      bit          rk;

      reset = 1'b1; start = 1'b0; op = 2'd0; data_in = '0; shamt = '0;
      last_result = '0;
      repeat (3) @(negedge clk);
      chk("reset/busy", 32'(busy), 32'd0);
      chk("reset/done", 32'(done), 32'd0);
      chk("reset/result", result, 32'd0);
      reset = 1'b0;

      // abort a long SLL mid-shift
      @(negedge clk);
      issue(2'd0, 32'h0000_0001, 5'd20);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort/busy", 32'(busy), 32'd0);
      chk("abort/done", 32'(done), 32'd0);
      chk("abort/result", result, 32'd0);
      any_done = 0;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) any_done = 1;
      end
      chk("abort/no_done", 32'(any_done), 32'd0);

      issue(2'd0, 32'h0000_0001, 5'd31);  finish_op("sll31", 2'd0, 32'h0000_0001, 5'd31, 0);
      chk("sll31/value", last_result, 32'h8000_0000);
      issue(2'd2, 32'h8000_00F0, 5'd4);   finish_op("sra4", 2'd2, 32'h8000_00F0, 5'd4, 0);
      chk("sra4/value", result, 32'hF800_000F);
      issue(2'd1, 32'h8000_00F0, 5'd4);   finish_op("srl4", 2'd1, 32'h8000_00F0, 5'd4, 0);
      chk("srl4/value", result, 32'h0800_000F);
      issue(2'd3, 32'h1234_5678, 5'd8);   finish_op("ror8", 2'd3, 32'h1234_5678, 5'd8, 0);
      chk("ror8/value", result, 32'h7812_3456);
      issue(2'd3, 32'h1234_5678, 5'd0);   finish_op("ror0", 2'd3, 32'h1234_5678, 5'd0, 0);
      chk("ror0/value", result, 32'h1234_5678);

      // back-to-back issue from the DONE cycle
      issue(2'd0, 32'h0000_00A5, 5'd3);   finish_op("pre_b2b", 2'd0, 32'h0000_00A5, 5'd3, 1);
      issue(2'd1, 32'hFFFF_FFFF, 5'd1);   finish_op("b2b", 2'd1, 32'hFFFF_FFFF, 5'd1, 1);
      chk("b2b/value", result, 32'h7FFF_FFFF);
      issue(2'd2, 32'hC000_0000, 5'd0);   finish_op("b2b0", 2'd2, 32'hC000_0000, 5'd0, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         rd = $urandom;
         rs = 5'($urandom);
         rk = (i < 39) ? 1'($urandom) : 1'b0;
         issue(ro, rd, rs);
         finish_op($sformatf("rand%0d", i), ro, rd, rs, rk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
